// File: rtl/pwm_audio_pkg.sv
// pwm_audio_pkg: shared constants and helpers for the PWM / sigma-delta audio DAC.
// Contents:
//   MODE_PWM / MODE_SD  encodings of the mode input
//   clog2(n)            counter width for a frame of n clocks (never below 1)
package pwm_audio_pkg;
    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_SD  = 1'b1;

    function automatic int clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/pwm_audio_chan.sv
// pwm_audio_chan: one DAC output channel, PWM comparator or 1st-order sigma-delta modulator.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_cnt           frame position from the top-level counter
//   i_mode_q        mode latched at the last frame boundary (MODE_PWM / MODE_SD)
//   i_load, i_data  load strobe and new sample for the active register
//   i_clr_acc       clears the sigma-delta accumulator (mode change at a boundary)
//   o_pwm           registered output bit
module pwm_audio_chan
    import pwm_audio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CW-1:0]    i_cnt,
    input  logic             i_mode_q,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clr_acc,
    output logic             o_pwm
);
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_cnt;

    // CW never exceeds WIDTH because the frame is at most 2**WIDTH clocks
    assign w_cnt = WIDTH'(i_cnt);
    assign w_sum = {1'b0, r_acc} + {1'b0, r_active};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active <= '0;
            r_acc    <= '0;
            o_pwm    <= 1'b0;
        end else begin
            o_pwm <= (i_mode_q == MODE_SD) ? w_sum[WIDTH] : (w_cnt < r_active);
            if (i_load)
                r_active <= i_data;
            // the accumulator only advances in sigma-delta mode and is frozen otherwise
            if (i_clr_acc)
                r_acc <= '0;
            else if (i_mode_q == MODE_SD)
                r_acc <= w_sum[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/pwm_audio_dac.sv
// pwm_audio_dac: multi-channel audio DAC output stage with a one-deep sample holding buffer.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_mode            0 = PWM, 1 = sigma-delta; taken at the frame boundary
//   i_sample          packed samples, channel c at [c*WIDTH +: WIDTH]
//   i_sample_valid    new frame of samples offered
//   o_sample_ready    holding buffer empty (and not in reset)
//   o_pwm             per-channel registered output bits
//   o_frame_strobe    1-clk pulse after each frame boundary
//   o_underrun        1-clk pulse after a boundary that found the buffer empty
module pwm_audio_dac
    import pwm_audio_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int PERIOD   = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mode,
    input  logic [WIDTH*CHANNELS-1:0] i_sample,
    input  logic                      i_sample_valid,
    output logic                      o_sample_ready,
    output logic [CHANNELS-1:0]       o_pwm,
    output logic                      o_frame_strobe,
    output logic                      o_underrun
);
    localparam int            CW   = clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0]             r_cnt;
    logic [WIDTH*CHANNELS-1:0] r_hold;
    logic                      r_hold_full;
    logic                      r_mode_q;
    logic                      w_boundary;
    logic                      w_xfer;
    logic                      w_load;
    logic                      w_clr_acc;

    assign w_boundary     = (r_cnt == LAST);
    assign o_sample_ready = !r_hold_full && !i_rst;
    assign w_xfer         = i_sample_valid && o_sample_ready;
    // a transfer landing on the boundary edge only fills hold; it is consumed a frame later
    assign w_load         = w_boundary && r_hold_full;
    assign w_clr_acc      = w_boundary && (i_mode != r_mode_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt          <= '0;
            r_hold         <= '0;
            r_hold_full    <= 1'b0;
            r_mode_q       <= MODE_PWM;
            o_frame_strobe <= 1'b0;
            o_underrun     <= 1'b0;
        end else begin
            r_cnt          <= w_boundary ? '0 : r_cnt + CW'(1);
            o_frame_strobe <= w_boundary;
            o_underrun     <= w_boundary && !r_hold_full;
            if (w_boundary)
                r_mode_q <= i_mode;
            if (w_xfer) begin
                r_hold      <= i_sample;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        pwm_audio_chan #(
            .WIDTH (WIDTH),
            .CW    (CW)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_cnt     (r_cnt),
            .i_mode_q  (r_mode_q),
            .i_load    (w_load),
            .i_data    (r_hold[c*WIDTH +: WIDTH]),
            .i_clr_acc (w_clr_acc),
            .o_pwm     (o_pwm[c])
        );
    end
endmodule
